// File: rtl/div_iter.sv
// Radix-2 restoring divider (DIV/DIVU) with start/annul/ready handshake and divide-by-zero flag.
// Optional: define DIV_EARLY_TERM_EN to skip leading zero bits of the dividend.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // BYZERO | divisor was zero, one settling cycle
  // ON     | one quotient bit per cycle
  // END    | result held until start_i drops
  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, last_cnt;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               dbz_flag_q, dbz_flag_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d, busy_q, busy_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_abs, b_abs, a_init;
  logic [WIDTH:0]     shifted, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz, last_q, last_d;

  always_comb begin
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_abs[i]) lz = CNT_W'(WIDTH - 1 - i);
    end
    // a zero dividend still runs one (trivial) iteration
    last_d = (a_abs == '0) ? '0 : CNT_W'(WIDTH - 1) - lz;
  end

  assign a_init   = a_abs << lz;
  assign last_cnt = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (state_q == S_IDLE) begin
      last_q <= last_d;
    end
  end
`else
  assign a_init   = a_abs;
  assign last_cnt = CNT_W'(WIDTH - 1);
`endif

  // borrow out of the (WIDTH+1)-bit trial subtract means the divisor did not fit
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dvsr_d     = b_abs;
          quo_d      = a_init;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
          dbz_flag_d = (opdata2_i == '0);
          state_d    = dbz_flag_d ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = '0;
          quo_d   = '0;
          state_d = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          if (cnt_q == last_cnt) begin
            quo_d   = neg_quo_q ? -quo_nxt : quo_nxt;
            rem_d   = neg_rem_q ? -rem_nxt : rem_nxt;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (!start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // first END cycle always presents the result; later cycles only while start_i holds
    ready_d  = (state_q == S_END) && (start_i || !ready_q);
    result_d = ready_d ? {rem_q, quo_q} : '0;
    dbz_d    = ready_d && dbz_flag_q;
    busy_d   = (state_d == S_BYZERO) || (state_d == S_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (default build, WIDTH=32) against an arithmetic reference.
module tb_div_iter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, signed_div, start, annul;
  logic [W-1:0]   op1, op2;
  logic [2*W-1:0] result;
  logic           ready, busy, dbz;
  int             total = 0;
  int             bad = 0;

  div_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy),
    .dbz_o(dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // {remainder, quotient} from plain 64-bit arithmetic; division truncates toward zero
  function automatic logic [2*W-1:0] ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    return (b == '0) ? 2 : W + 1;
  endfunction

  // start held; returns edges from the start edge until ready_o is seen (-1 on timeout)
  task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] res, output logic dz,
                         output logic bsy_t, output logic bsy_r);
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    bsy_t = busy;
    signed_div = 1'($urandom); op1 = $urandom; op2 = $urandom;
    lat = -1; res = '0; dz = 1'b0; bsy_r = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = i; res = result; dz = dbz; bsy_r = busy;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL run_timeout: ready_o never rose for %h/%h", a, b);
    end
  endtask

  task automatic release_div();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL release_ready: got %b want 0", ready); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL release_dbz: got %b want 0", dbz); end
    total++; if (result !== '0) begin bad++; $display("FAIL release_result: got %h want 0", result); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    run_div(1'b0, 32'd100, 32'd7, lat, res, dz, bt, br);
    total++; if (lat !== 33) begin bad++; $display("FAIL udiv_latency: got %0d want 33", lat); end
    total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL udiv_result: got %h want %h", res, {32'd2, 32'd14}); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL udiv_dbz: got %b want 0", dz); end
    total++; if (bt !== 1'b1) begin bad++; $display("FAIL udiv_busy_start: got %b want 1", bt); end
    total++; if (br !== 1'b0) begin bad++; $display("FAIL udiv_busy_ready: got %b want 0", br); end
    release_div();
  endtask

  task automatic test_signed();
    logic [W-1:0] a_tab [2] = '{32'hFFFF_FFF9, 32'd7};
    logic [W-1:0] b_tab [2] = '{32'd2, 32'hFFFF_FFFE};
    logic [2*W-1:0] e_tab [2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0001, 32'hFFFF_FFFD}};
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    for (int k = 0; k < 2; k++) begin
      run_div(1'b1, a_tab[k], b_tab[k], lat, res, dz, bt, br);
      total++; if (res !== e_tab[k]) begin bad++; $display("FAIL sdiv_result[%0d]: got %h want %h", k, res, e_tab[k]); end
      total++; if (lat !== 33) begin bad++; $display("FAIL sdiv_latency[%0d]: got %0d want 33", k, lat); end
      release_div();
    end
  endtask

  task automatic test_dbz();
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    for (int k = 0; k < 2; k++) begin
      run_div(k[0], (k == 0) ? 32'd12345 : 32'hFFFF_FFFB, 32'd0, lat, res, dz, bt, br);
      total++; if (lat !== 2) begin bad++; $display("FAIL dbz_latency[%0d]: got %0d want 2", k, lat); end
      total++; if (res !== '0) begin bad++; $display("FAIL dbz_result[%0d]: got %h want 0", k, res); end
      total++; if (dz !== 1'b1) begin bad++; $display("FAIL dbz_flag[%0d]: got %b want 1", k, dz); end
      total++; if (bt !== 1'b1) begin bad++; $display("FAIL dbz_busy[%0d]: got %b want 1", k, bt); end
      release_div();
    end
  endtask

  task automatic test_annul();
    int highs = 0; int lat; logic [2*W-1:0] res; logic dz, bt, br;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL annul_busy: got %b want 0", busy); end
    @(negedge clk);
    annul = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) highs++;
    end
    total++; if (highs !== 0) begin bad++; $display("FAIL annul_no_ready: got %0d ready cycles want 0", highs); end
    run_div(1'b0, 32'd9, 32'd3, lat, res, dz, bt, br);
    total++; if (res !== {32'd0, 32'd3}) begin bad++; $display("FAIL annul_next_result: got %h want %h", res, {32'd0, 32'd3}); end
    total++; if (lat !== 33) begin bad++; $display("FAIL annul_next_latency: got %0d want 33", lat); end
    // annul in END is ignored
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL annul_in_end: got %b want 1", ready); end
    annul = 1'b0;
    release_div();
  endtask

  task automatic test_overflow_hold();
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    logic [2*W-1:0] exp_res;
    exp_res = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, dz, bt, br);
    total++; if (res !== {32'd0, 32'h8000_0000}) begin bad++; $display("FAIL ovf_result: got %h want %h", res, {32'd0, 32'h8000_0000}); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL ovf_dbz: got %b want 0", dz); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 1", i, ready); end
      total++; if (result !== exp_res) begin bad++; $display("FAIL hold_result[%0d]: got %h want %h", i, result, exp_res); end
    end
    release_div();
  endtask

  task automatic test_start_drop();
    int pulses = 0; int at = -1; logic [2*W-1:0] seen = '0;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 6; i <= 50; i++) begin
      @(posedge clk); #1;
      if (ready) begin pulses++; at = i; seen = result; end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    total++; if (at !== 33) begin bad++; $display("FAIL drop_pulse_edge: got %0d want 33", at); end
    total++; if (seen !== ref_div(1'b0, 32'd1000, 32'd7)) begin bad++; $display("FAIL drop_result: got %h want %h", seen, ref_div(1'b0, 32'd1000, 32'd7)); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd3; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", ready); end
    total++; if (result !== '0) begin bad++; $display("FAIL mid_rst_result: got %h want 0", result); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL mid_rst_dbz: got %b want 0", dbz); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    run_div(1'b0, 32'd50, 32'd3, lat, res, dz, bt, br);
    total++; if (res !== {32'd2, 32'd16}) begin bad++; $display("FAIL mid_after_result: got %h want %h", res, {32'd2, 32'd16}); end
    release_div();
  endtask

  task automatic test_random();
    int lat; logic [2*W-1:0] res; logic dz, bt, br;
    bit sgn; logic [W-1:0] a, b;
    for (int n = 0; n < 24; n++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (n % 5 == 0) a = W'($urandom_range(0, 200));
      run_div(sgn, a, b, lat, res, dz, bt, br);
      total++; if (res !== ref_div(sgn, a, b)) begin bad++; $display("FAIL rand_result[%0d] s=%0d %h/%h: got %h want %h", n, sgn, a, b, res, ref_div(sgn, a, b)); end
      total++; if (lat !== ref_lat(b)) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, ref_lat(b)); end
      total++; if (dz !== (b == '0)) begin bad++; $display("FAIL rand_dbz[%0d]: got %b want %b", n, dz, (b == '0)); end
      release_div();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_annul();
    test_overflow_hold();
    test_start_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
